conv3x3_sched: RTL
==================

CONV3X3_SCHED -- requirements
Module: conv3x3_sched

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels; legal range 3..1024.
REQ-002 Parameter IMG_H, default 28, image height in pixels; legal range 3..1024.
REQ-003 Parameter CNT_W, default 20, width of the pixel and result counters; must satisfy 2^CNT_W > IMG_W*IMG_H.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that begins one image pass; honoured only in IDLE.
REQ-007 pix_in  in  32  FP32 pixel, raster order.
REQ-008 pix_valid  in  1  pix_in is valid.
REQ-009 pix_ready  out  1  scheduler accepts a pixel this cycle.
REQ-010 win_data  out  288  3x3 window, 9 x 32 bits; bits [32k+31:32k] carry window element k, k=0 top-left, row-major, k=8 bottom-right.
REQ-011 win_valid  out  1  win_data is valid; drives the filter datapath input_valid.
REQ-012 res_valid  in  1  filter datapath output_valid.
REQ-013 res_data  in  32  filter datapath data_out.
REQ-014 out_valid  out  1  out_data and out_addr are valid.
REQ-015 out_data  out  32  registered copy of res_data.
REQ-016 out_addr  out  CNT_W  result index, row-major over the (IMG_W-2) x (IMG_H-2) output map.
REQ-017 busy  out  1  high in STREAM and DRAIN.
REQ-018 done  out  1  one-cycle pulse at the end of a pass.

Function
REQ-019 The FSM SHALL have states IDLE, STREAM, DRAIN and DONE, and SHALL start in IDLE.
REQ-020 IDLE SHALL go to STREAM on start=1, clearing the row, column and result counters in the same edge.
REQ-021 pix_ready SHALL be 1 only in STREAM; a pixel is accepted when pix_valid and pix_ready are both 1, and pix_valid=0 SHALL stall all counters and the window.
REQ-022 Each accepted pixel SHALL be stored in two IMG_W-deep line buffers (rows r-1 and r-2) and shifted into a 3x3 window register.
REQ-023 The column counter SHALL wrap from IMG_W-1 to 0, and the row counter SHALL then increment.
REQ-024 win_valid SHALL be 1 for exactly one cycle, in the cycle after a pixel at (r,c) with r>=2 and c>=2 is accepted; in all other cycles it SHALL be 0.
REQ-025 With win_valid=1, win_data SHALL hold the pixels of rows r-2..r and columns c-2..c; windows SHALL never span a row wrap.
REQ-026 Acceptance of pixel (IMG_H-1, IMG_W-1) SHALL move the FSM to DRAIN, with pix_ready=0 from the next cycle.
REQ-027 On each cycle with res_valid=1 in STREAM or DRAIN:
  - out_valid SHALL be 1 in the following cycle;
  - out_data SHALL equal res_data;
  - out_addr SHALL equal the current result count;
  - the result count SHALL then increment.
REQ-028 out_valid SHALL be 0 in every cycle not covered by REQ-027.
REQ-029 res_valid in IDLE or DONE SHALL be ignored: no out_valid and no count change.
REQ-030 A pixel accept and res_valid in the same cycle SHALL both take effect.
REQ-031 DRAIN SHALL go to DONE in the cycle after the result count reaches (IMG_W-2)*(IMG_H-2).
REQ-032 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-033 start in STREAM, DRAIN or DONE SHALL be ignored.
REQ-034 The scheduler applies no backpressure to results; the datapath latency is arbitrary but fixed, and results arrive in window order.

Reset
REQ-035 With rst=1, the FSM SHALL be IDLE and all counters SHALL be 0.
REQ-036 With rst=1, pix_ready, win_valid, out_valid, busy and done SHALL be 0, and win_data, out_data and out_addr SHALL be 0.
REQ-037 Line buffer contents are not reset.
REQ-038 Reset asserted mid-pass SHALL abort the pass with no done pulse; the next start SHALL begin a clean pass.

Verification
REQ-039 IMG 4x4, pixels valued 0..15 streamed back-to-back -> four win_valid pulses; the first has win_data k0..k8 = 0,1,2,4,5,6,8,9,10 and the last = 5,6,7,9,10,11,13,14,15.
REQ-040 Same stream through a datapath model with 3-cycle latency and sum output -> out_addr 0..3 with out_data 45,54,81,90, then done high one cycle, then IDLE with busy=0.
REQ-041 pix_valid toggled 1,0,1,0 for the whole stream -> window contents identical to REQ-039 and no win_valid in stall cycles.
REQ-042 start pulsed during STREAM, and res_valid pulsed in IDLE -> no effect on counters, and out_valid stays 0.
REQ-043 rst asserted after 9 pixels of a 4x4 pass, then start with a fresh stream -> no done from the aborted pass; the new pass matches REQ-039 and REQ-040 exactly.
REQ-044 IMG 3x3 (minimum size) -> exactly one window, then out_addr 0, then done.

Source files
------------

// File: rtl/conv3x3_sched_if.sv
// rtl/conv3x3_sched_if.sv - pixel stream, window and result bundle for the 3x3 convolution scheduler
interface conv3x3_sched_if #(
    parameter int CNT_W = 20
);
    logic             start;
    logic [31:0]      pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [287:0]     win_data;
    logic             win_valid;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_addr;
    logic             busy;
    logic             done;

    modport master (
        output start, pix_in, pix_valid, res_valid, res_data,
        input  pix_ready, win_data, win_valid, out_valid, out_data, out_addr, busy, done
    );

    modport slave (
        input  start, pix_in, pix_valid, res_valid, res_data,
        output pix_ready, win_data, win_valid, out_valid, out_data, out_addr, busy, done
    );
endinterface

// File: rtl/conv3x3_sched.sv
// rtl/conv3x3_sched.sv - raster pixel stream to 3x3 windows, filter results back to indexed output
module conv3x3_sched #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = 20
) (
    input  logic            clk,
    input  logic            rst,
    conv3x3_sched_if.slave  bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [CNT_W-1:0] N_RES   = CNT_W'((IMG_W - 2) * (IMG_H - 2));
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] res_cnt;
    logic             pix_ready_r;
    logic             win_valid_r;
    logic             out_valid_r;
    logic [31:0]      out_data_r;
    logic [CNT_W-1:0] out_addr_r;
    logic             busy_r;
    logic             done_r;

    // lb1 holds row r-1, lb2 holds row r-2, both indexed by column
    logic [31:0] lb1 [IMG_W];
    logic [31:0] lb2 [IMG_W];
    // window element k = 3*row + col, row 0 oldest line, col 2 newest pixel
    logic [31:0] win [9];

    logic accept;
    logic last_pix;
    logic res_take;

    assign accept   = bus.pix_valid && pix_ready_r;
    assign last_pix = accept && (col == COL_MAX) && (row == ROW_MAX);
    assign res_take = bus.res_valid && ((state == STREAM) || (state == DRAIN));

    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            res_cnt     <= '0;
            pix_ready_r <= 1'b0;
            win_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_addr_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            win_valid_r <= 1'b0;
            out_valid_r <= 1'b0;

            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win[3*i]   <= win[3*i+1];
                    win[3*i+1] <= win[3*i+2];
                end
                win[2] <= lb2[col];
                win[5] <= lb1[col];
                win[8] <= bus.pix_in;
                win_valid_r <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (res_take) begin
                out_valid_r <= 1'b1;
                out_data_r  <= bus.res_data;
                out_addr_r  <= res_cnt;
                res_cnt     <= res_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state       <= STREAM;
                        col         <= '0;
                        row         <= '0;
                        res_cnt     <= '0;
                        pix_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last_pix) begin
                        state       <= DRAIN;
                        pix_ready_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (res_cnt == N_RES) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.win_data = '0;
        for (int k = 0; k < 9; k++) begin
            bus.win_data[32*k +: 32] = win[k];
        end
    end

    assign bus.pix_ready = pix_ready_r;
    assign bus.win_valid = win_valid_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule
